// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file.
// Keeps the datapath-wide sizing constants in one place.
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NUM_RD = 3;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_entry.sv
// One register-file word plus its busy bit; a new reservation beats a
// completing write so the latest producer stays tracked.
module rf_entry #(
  parameter int DATA_W  = 16,
  parameter bit IS_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_busy,
  input  logic              clr_busy,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  if (IS_ZERO) begin : g_zero
    // Hardwired zero: every write and reservation is dropped.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, wr_en, wr_data, set_busy, clr_busy};
    assign data = '0;
    assign busy = 1'b0;
  end else begin : g_store
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data <= '0;
        busy <= 1'b0;
      end else begin
        if (wr_en) begin
          data <= wr_data;
        end
        if (set_busy) begin
          busy <= 1'b1;
        end else if (clr_busy) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised multi-port register file with a per-entry busy scoreboard.
// Writes and reservations land on rising CLK; read ports capture on falling CLK.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 0
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Reg_Write,
  input  logic [ADDR_W-1:0]        Wr_addr,
  input  logic [DATA_W-1:0]        Reg_input_data,
  input  logic [NUM_RD*ADDR_W-1:0] Rd_addr,
  input  logic [NUM_RD-1:0]        Rd_en,
  output logic [NUM_RD*DATA_W-1:0] Rd_data,
  output logic [NUM_RD-1:0]        Rd_busy,
  input  logic                     Rsv_valid,
  input  logic [ADDR_W-1:0]        Rsv_addr,
  output logic [(2**ADDR_W)-1:0]   Busy_vec
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [DEPTH-1:0]  entry_busy;

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    localparam bit IS_ZERO = (ZERO_REG != 0) && (k == 0);

    logic wr_hit;
    logic rsv_hit;

    assign wr_hit  = Reg_Write && (Wr_addr == ADDR_W'(k));
    assign rsv_hit = Rsv_valid && (Rsv_addr == ADDR_W'(k));

    rf_entry #(
      .DATA_W  (DATA_W),
      .IS_ZERO (IS_ZERO)
    ) u_entry (
      .clk      (CLK),
      .rst      (Reset),
      .wr_en    (wr_hit),
      .wr_data  (Reg_input_data),
      .set_busy (rsv_hit),
      .clr_busy (wr_hit),
      .data     (entry_data[k]),
      .busy     (entry_busy[k])
    );
  end

  assign Busy_vec = entry_busy;

  // Falling-edge capture gives same-cycle visibility of a rising-edge write
  // without a bypass; data and busy are sampled together so they always agree.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_busy;
    logic [DATA_W-1:0] port_data;
    logic              port_busy;

    assign addr = Rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      sel_data = '0;
      sel_busy = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (addr == ADDR_W'(k)) begin
          sel_data = entry_data[k];
          sel_busy = entry_busy[k];
        end
      end
    end

    always_ff @(negedge CLK or posedge Reset) begin
      if (Reset) begin
        port_data <= '0;
        port_busy <= 1'b0;
      end else if (Rd_en[i]) begin
        port_data <= sel_data;
        port_busy <= sel_busy;
      end
    end

    assign Rd_data[i*DATA_W +: DATA_W] = port_data;
    assign Rd_busy[i]                  = port_busy;
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default, zero-register and wide variants.
module tb_register_file_param;

  logic        clk;
  logic        Reset;
  logic        reg_write;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [8:0]  rd_addr;
  logic [2:0]  rd_en;
  logic        rsv_valid;
  logic [2:0]  rsv_addr;

  logic [47:0] rd_data,  z_rd_data;
  logic [2:0]  rd_busy,  z_rd_busy;
  logic [7:0]  busy_vec, z_busy_vec;

  logic        p_write;
  logic [3:0]  p_wr_addr;
  logic [31:0] p_wr_data;
  logic [7:0]  p_rd_addr;
  logic [1:0]  p_rd_en;
  logic        p_rsv_valid;
  logic [3:0]  p_rsv_addr;
  logic [63:0] p_rd_data;
  logic [1:0]  p_rd_busy;
  logic [15:0] p_busy_vec;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        wr;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        rsv;
    logic [2:0]  raddr;
    logic [2:0]  en;
    logic [2:0]  a0, a1, a2;
    logic [15:0] d0, d1, d2;
    logic [2:0]  busy;
    logic [7:0]  vec;
  } vec_t;

  vec_t vecs [10];

  register_file_param dut (
    .CLK(clk), .Reset(Reset), .Reg_Write(reg_write), .Wr_addr(wr_addr),
    .Reg_input_data(wr_data), .Rd_addr(rd_addr), .Rd_en(rd_en),
    .Rd_data(rd_data), .Rd_busy(rd_busy), .Rsv_valid(rsv_valid),
    .Rsv_addr(rsv_addr), .Busy_vec(busy_vec)
  );

  register_file_param #(.ZERO_REG(1)) zdut (
    .CLK(clk), .Reset(Reset), .Reg_Write(reg_write), .Wr_addr(wr_addr),
    .Reg_input_data(wr_data), .Rd_addr(rd_addr), .Rd_en(rd_en),
    .Rd_data(z_rd_data), .Rd_busy(z_rd_busy), .Rsv_valid(rsv_valid),
    .Rsv_addr(rsv_addr), .Busy_vec(z_busy_vec)
  );

  register_file_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) pdut (
    .CLK(clk), .Reset(Reset), .Reg_Write(p_write), .Wr_addr(p_wr_addr),
    .Reg_input_data(p_wr_data), .Rd_addr(p_rd_addr), .Rd_en(p_rd_en),
    .Rd_data(p_rd_data), .Rd_busy(p_rd_busy), .Rsv_valid(p_rsv_valid),
    .Rsv_addr(p_rsv_addr), .Busy_vec(p_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the falling edge.
  task automatic applyStimulus(input logic wr, input logic [2:0] waddr, input logic [15:0] wdata,
                               input logic rsv, input logic [2:0] raddr, input logic [2:0] en,
                               input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    reg_write = wr;
    wr_addr   = waddr;
    wr_data   = wdata;
    rsv_valid = rsv;
    rsv_addr  = raddr;
    rd_en     = en;
    rd_addr   = {a2, a1, a0};
    @(negedge clk);
    #1;
  endtask

  task automatic checkMain(input string name, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [2:0] busy, input logic [7:0] vec);
    checkOutput({name, " data0"}, 64'(rd_data[15:0]),  64'(d0));
    checkOutput({name, " data1"}, 64'(rd_data[31:16]), 64'(d1));
    checkOutput({name, " data2"}, 64'(rd_data[47:32]), 64'(d2));
    checkOutput({name, " rd_busy"}, 64'(rd_busy), 64'(busy));
    checkOutput({name, " busy_vec"}, 64'(busy_vec), 64'(vec));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    Reset = 1'b0;
    reg_write = 1'b0; wr_addr = '0; wr_data = '0; rsv_valid = 1'b0; rsv_addr = '0;
    rd_en = '0; rd_addr = '0;
    p_write = 1'b0; p_wr_addr = '0; p_wr_data = '0; p_rd_addr = '0; p_rd_en = '0;
    p_rsv_valid = 1'b0; p_rsv_addr = '0;

    // {wr, waddr, wdata, rsv, raddr, en, a0, a1, a2, d0, d1, d2, busy{p2,p1,p0}, vec}
    vecs[0] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'b111, 3'd7, 3'd0, 3'd3,
                16'h1007, 16'h1000, 16'h1003, 3'b000, 8'h00};
    vecs[1] = '{1'b1, 3'd2, 16'h00A5, 1'b0, 3'd0, 3'b111, 3'd1, 3'd2, 3'd6,
                16'h1001, 16'h00A5, 16'h1006, 3'b000, 8'h00};
    vecs[2] = '{1'b1, 3'd2, 16'hFFFF, 1'b0, 3'd0, 3'b101, 3'd2, 3'd5, 3'd2,
                16'hFFFF, 16'h00A5, 16'hFFFF, 3'b000, 8'h00};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'b111, 3'd4, 3'd4, 3'd0,
                16'h1004, 16'h1004, 16'h1000, 3'b011, 8'h10};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'b010, 3'd0, 3'd2, 3'd0,
                16'h1004, 16'hFFFF, 16'h1000, 3'b001, 8'h10};
    vecs[5] = '{1'b1, 3'd4, 16'h1234, 1'b0, 3'd0, 3'b111, 3'd4, 3'd4, 3'd4,
                16'h1234, 16'h1234, 16'h1234, 3'b000, 8'h00};
    vecs[6] = '{1'b1, 3'd4, 16'h5678, 1'b1, 3'd4, 3'b111, 3'd4, 3'd4, 3'd4,
                16'h5678, 16'h5678, 16'h5678, 3'b111, 8'h10};
    vecs[7] = '{1'b1, 3'd6, 16'h0BAD, 1'b0, 3'd0, 3'b111, 3'd6, 3'd4, 3'd6,
                16'h0BAD, 16'h5678, 16'h0BAD, 3'b010, 8'h10};
    vecs[8] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'b111, 3'd1, 3'd4, 3'd7,
                16'h1001, 16'h5678, 16'h1007, 3'b011, 8'h12};
    vecs[9] = '{1'b1, 3'd1, 16'h4321, 1'b0, 3'd0, 3'b111, 3'd1, 3'd1, 3'd4,
                16'h4321, 16'h4321, 16'h5678, 3'b100, 8'h10};

    // Power-on reset
    #1 Reset = 1'b1;
    #1;
    checkOutput("por rd_data", 64'(rd_data), 64'h0);
    checkOutput("por busy_vec", 64'(busy_vec), 64'h0);
    repeat (2) @(negedge clk);
    #1 Reset = 1'b0;

    // Mid-cycle reset after writing r5 and reserving r3
    applyStimulus(1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd3, 3'b111, 3'd5, 3'd3, 3'd5);
    checkOutput("pre-reset data0", 64'(rd_data[15:0]), 64'hBEEF);
    checkOutput("pre-reset busy1", 64'(rd_busy[1]), 64'h1);
    checkOutput("pre-reset busy_vec", 64'(busy_vec), 64'h08);
    reg_write = 1'b0;
    rsv_valid = 1'b0;
    @(posedge clk);
    #2 Reset = 1'b1;
    #1;
    checkOutput("async rd_data", 64'(rd_data), 64'h0);
    checkOutput("async rd_busy", 64'(rd_busy), 64'h0);
    checkOutput("async busy_vec", 64'(busy_vec), 64'h0);
    checkOutput("async z rd_data", 64'(z_rd_data), 64'h0);
    checkOutput("async p rd_data", p_rd_data, 64'h0);
    @(negedge clk);
    #1 Reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'b111, 3'd5, 3'd5, 3'd5);
    checkMain("post-reset r5", 16'h0000, 16'h0000, 16'h0000, 3'b000, 8'h00);

    // Write sweep r0..r7
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, 3'(k), 16'h1000 + 16'(k), 1'b0, 3'd0, 3'b000, 3'd0, 3'd0, 3'd0);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'b111, 3'd7, 3'd0, 3'd3);
    checkMain("sweep", 16'h1007, 16'h1000, 16'h1003, 3'b000, 8'h00);
    checkOutput("zero sweep data0", 64'(z_rd_data[15:0]),  64'h1007);
    checkOutput("zero sweep data1", 64'(z_rd_data[31:16]), 64'h0000);
    checkOutput("zero sweep data2", 64'(z_rd_data[47:32]), 64'h1003);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].rsv, vecs[i].raddr,
                    vecs[i].en, vecs[i].a0, vecs[i].a1, vecs[i].a2);
      checkMain($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].busy, vecs[i].vec);
    end

    // Write plus reserve of r0: stored in the plain file, dropped by the zero-register variant
    applyStimulus(1'b1, 3'd0, 16'h7777, 1'b1, 3'd0, 3'b111, 3'd0, 3'd4, 3'd0);
    checkMain("r0 write", 16'h7777, 16'h5678, 16'h7777, 3'b111, 8'h11);
    checkOutput("zero r0 data0", 64'(z_rd_data[15:0]),  64'h0000);
    checkOutput("zero r4 data1", 64'(z_rd_data[31:16]), 64'h5678);
    checkOutput("zero rd_busy", 64'(z_rd_busy), 64'(3'b010));
    checkOutput("zero busy_vec", 64'(z_busy_vec), 64'h10);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'b000, 3'd0, 3'd0, 3'd0);

    // Wide variant: 32-bit data, 16 entries, 2 read ports
    p_write = 1'b1; p_wr_addr = 4'd15; p_wr_data = 32'hDEADBEEF;
    p_rsv_valid = 1'b1; p_rsv_addr = 4'd15;
    p_rd_en = 2'b11; p_rd_addr = {4'd15, 4'd15};
    @(negedge clk);
    #1;
    checkOutput("wide data0", 64'(p_rd_data[31:0]),  64'hDEADBEEF);
    checkOutput("wide data1", 64'(p_rd_data[63:32]), 64'hDEADBEEF);
    checkOutput("wide rd_busy", 64'(p_rd_busy), 64'h3);
    checkOutput("wide busy_vec", 64'(p_busy_vec), 64'h8000);
    p_wr_addr = 4'd0; p_wr_data = 32'hCAFEF00D; p_rsv_valid = 1'b0;
    p_rd_addr = {4'd15, 4'd0};
    @(negedge clk);
    #1;
    checkOutput("wide r0 data0", 64'(p_rd_data[31:0]),  64'hCAFEF00D);
    checkOutput("wide r15 data1", 64'(p_rd_data[63:32]), 64'hDEADBEEF);
    checkOutput("wide rd_busy 2", 64'(p_rd_busy), 64'h2);
    checkOutput("wide busy_vec 2", 64'(p_busy_vec), 64'h8000);
    p_write = 1'b0;
    p_rd_en = 2'b00;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
